// File: rtl/fifo_pkg.sv
// Shared types and pointer-coding helpers for the FIFO write side.
// Helpers work on 32-bit words; callers zero-extend narrower pointers and truncate the result.
package fifo_pkg;

  localparam int D_SIZE_DEF    = 8;
  localparam int A_SIZE_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef logic [31:0] ptr_word_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } wr_state_e;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Write side of an async FIFO shared by two producers: burst arbiter, pointers, flags.
// state | meaning
// IDLE  | no owner; arbitrate, no grants
// OWN0  | producer 0 owns the write port
// OWN1  | producer 1 owns the write port
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int D_Size    = D_SIZE_DEF,
  parameter int A_Size    = A_SIZE_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [D_Size-1:0] wdata0,
  input  logic [D_Size-1:0] wdata1,
  input  logic [A_Size:0]   wq2_rptr,
  output logic              gnt0,
  output logic              gnt1,
  output logic              w_inc,
  output logic [D_Size-1:0] wdata,
  output logic [A_Size:0]   waddr,
  output logic [A_Size:0]   wptr,
  output logic              wfull,
  output logic              hfull
);

  localparam int PTR_W = A_Size + 1;
  // beat_cnt is 2 bits wide, so MAX_BURST is limited to 1..4
  localparam logic [1:0]       BURST_LAST = 2'(MAX_BURST - 1);
  localparam logic [PTR_W-1:0] HALF_LVL   = PTR_W'(2 ** (A_Size - 1));

  wr_state_e        state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [1:0]       beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0] bin_q, bin_d;
  logic [PTR_W-1:0] gray_q, gray_d;
  logic             wfull_q, wfull_d;
  logic             hfull_q, hfull_d;

  logic             own_req;
  logic             other_req;
  wr_state_e        other_state;
  logic [PTR_W-1:0] rptr_bin;
  logic [PTR_W-1:0] full_cmp;
  logic [PTR_W-1:0] occupancy;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    own_req      = (state_q == ST_OWN1) ? req1 : req0;
    other_req    = (state_q == ST_OWN1) ? req0 : req1;
    other_state  = (state_q == ST_OWN1) ? ST_OWN0 : ST_OWN1;

    case (state_q)
      ST_OWN0: gnt0 = req0 & ~wfull_q;
      ST_OWN1: gnt1 = req1 & ~wfull_q;
      default: ;
    endcase

    // A full FIFO freezes arbitration and the burst count
    if (!wfull_q) begin
      case (state_q)
        ST_IDLE: begin
          if (req0 && req1) begin
            state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
          end else if (req0) begin
            state_d = ST_OWN0;
          end else if (req1) begin
            state_d = ST_OWN1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (!own_req || (beat_cnt_q == BURST_LAST && other_req)) begin
            state_d      = other_req ? other_state : ST_IDLE;
            last_owner_d = (state_q == ST_OWN1);
          end else if (beat_cnt_q == BURST_LAST) begin
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != state_q) begin
      beat_cnt_d = '0;
    end
  end

  assign w_inc = gnt0 | gnt1;
  assign wdata = (state_q == ST_OWN1) ? wdata1 : wdata0;

  always_comb begin
    bin_d     = bin_q + PTR_W'(w_inc);
    gray_d    = PTR_W'(bin2gray(32'(bin_d)));
    rptr_bin  = PTR_W'(gray2bin(32'(wq2_rptr)));
    // Full when the write side is exactly one lap ahead of the read side
    full_cmp  = {~wq2_rptr[A_Size:A_Size-1], wq2_rptr[A_Size-2:0]};
    occupancy = bin_d - rptr_bin;
    wfull_d   = (gray_d == full_cmp);
    hfull_d   = (occupancy >= HALF_LVL);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      beat_cnt_q   <= '0;
      bin_q        <= '0;
      gray_q       <= '0;
      wfull_q      <= 1'b0;
      hfull_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      bin_q        <= bin_d;
      gray_q       <= gray_d;
      wfull_q      <= wfull_d;
      hfull_q      <= hfull_d;
    end
  end

  assign waddr = bin_q;
  assign wptr  = gray_q;
  assign wfull = wfull_q;
  assign hfull = hfull_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: single producer, contention, reset mid-burst,
// fill to full, drain while full and pointer wrap.
module tb_fifo_wr_arbiter;

  localparam int D_SIZE = 8;
  localparam int A_SIZE = 8;

  logic              w_clk = 1'b0;
  logic              w_rst;
  logic              req0, req1;
  logic [D_SIZE-1:0] wdata0, wdata1;
  logic [A_SIZE:0]   wq2_rptr;
  logic              gnt0, gnt1, w_inc;
  logic [D_SIZE-1:0] wdata;
  logic [A_SIZE:0]   waddr, wptr;
  logic              wfull, hfull;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arbiter #(.D_Size(D_SIZE), .A_Size(A_SIZE), .MAX_BURST(4)) dut (
    .w_clk    (w_clk),
    .w_rst    (w_rst),
    .req0     (req0),
    .req1     (req1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .wq2_rptr (wq2_rptr),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .w_inc    (w_inc),
    .wdata    (wdata),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull),
    .hfull    (hfull)
  );

  always #5 w_clk = ~w_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  function automatic logic [A_SIZE:0] gray_of(input int b);
    logic [A_SIZE:0] x;
    x = (A_SIZE+1)'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic do_reset(input logic r0, input logic r1);
    w_rst = 1'b1;
    req0  = r0;
    req1  = r1;
    tick();
    tick();
    w_rst = 1'b0;
  endtask

  initial begin
    w_rst    = 1'b1;
    req0     = 1'b0;
    req1     = 1'b0;
    wdata0   = '0;
    wdata1   = '0;
    wq2_rptr = '0;
    tick();
    tick();
    check_val("rst_gnt0", gnt0, 0);
    check_val("rst_gnt1", gnt1, 0);
    check_val("rst_winc", w_inc, 0);
    check_val("rst_waddr", waddr, 0);
    check_val("rst_wptr", wptr, 0);
    check_val("rst_wfull", wfull, 0);
    check_val("rst_hfull", hfull, 0);
    w_rst = 1'b0;

    // single producer, 10 beats
    req0 = 1'b1;
    #1;
    check_val("sp_idle_gnt0", gnt0, 0);
    check_val("sp_idle_winc", w_inc, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      wdata0 = 8'hA0 + 8'(k);
      #1;
      check_val("sp_gnt0", gnt0, 1);
      check_val("sp_gnt1", gnt1, 0);
      check_val("sp_winc", w_inc, 1);
      check_val("sp_wdata", wdata, 8'hA0 + k);
      check_val("sp_waddr", waddr, k);
      check_val("sp_wptr", wptr, gray_of(k));
      check_val("sp_hfull", hfull, 0);
      tick();
    end
    req0 = 1'b0;
    #1;
    check_val("sp_end_waddr", waddr, 10);
    check_val("sp_end_wptr", wptr, gray_of(10));
    check_val("sp_drop_gnt0", gnt0, 0);
    tick();

    // contention from reset: 4-beat bursts alternating, producer 0 first
    wdata0 = 8'h11;
    wdata1 = 8'h22;
    do_reset(1'b1, 1'b1);
    #1;
    check_val("ct_idle_gnt0", gnt0, 0);
    check_val("ct_idle_gnt1", gnt1, 0);
    tick();
    for (int i = 0; i < 14; i++) begin
      int own;
      own = (i / 4) % 2;
      #1;
      check_val("ct_gnt0", gnt0, (own == 0) ? 1 : 0);
      check_val("ct_gnt1", gnt1, (own == 1) ? 1 : 0);
      check_val("ct_both", gnt0 & gnt1, 0);
      check_val("ct_wdata", wdata, (own == 1) ? 8'h22 : 8'h11);
      check_val("ct_waddr", waddr, i);
      tick();
    end

    // reset at beat 2 of the OWN1 burst
    #1;
    check_val("rm_pre_gnt1", gnt1, 1);
    w_rst = 1'b1;
    #1;
    check_val("rm_gnt0", gnt0, 0);
    check_val("rm_gnt1", gnt1, 0);
    check_val("rm_winc", w_inc, 0);
    check_val("rm_waddr", waddr, 0);
    tick();
    w_rst = 1'b0;
    #1;
    check_val("rm_idle_gnt0", gnt0, 0);
    check_val("rm_idle_gnt1", gnt1, 0);
    check_val("rm_idle_waddr", waddr, 0);
    tick();
    #1;
    check_val("rm_first_gnt0", gnt0, 1);
    check_val("rm_first_gnt1", gnt1, 0);
    check_val("rm_first_waddr", waddr, 0);

    // fill to full with read pointer parked at 0
    wq2_rptr = '0;
    do_reset(1'b1, 1'b0);
    tick();
    for (int n = 0; n < 256; n++) begin
      #1;
      check_val("fl_gnt0", gnt0, 1);
      check_val("fl_hfull", hfull, (n >= 128) ? 1 : 0);
      check_val("fl_wfull", wfull, 0);
      tick();
    end
    #1;
    check_val("fl_full_wfull", wfull, 1);
    check_val("fl_full_hfull", hfull, 1);
    check_val("fl_full_gnt0", gnt0, 0);
    check_val("fl_full_winc", w_inc, 0);
    check_val("fl_full_waddr", waddr, 256);
    tick();
    #1;
    check_val("fl_hold_gnt0", gnt0, 0);
    check_val("fl_hold_waddr", waddr, 256);

    // one slot freed while full
    wq2_rptr = gray_of(1);
    #1;
    check_val("dr_same_gnt0", gnt0, 0);
    tick();
    #1;
    check_val("dr_wfull_low", wfull, 0);
    check_val("dr_gnt0", gnt0, 1);
    check_val("dr_waddr", waddr, 256);
    tick();
    #1;
    check_val("dr_wfull_again", wfull, 1);
    check_val("dr_gnt0_off", gnt0, 0);
    check_val("dr_waddr_after", waddr, 257);

    // wrap: read pointer trails the write pointer by 3
    wq2_rptr = gray_of(-3);
    do_reset(1'b1, 1'b0);
    wq2_rptr = gray_of(-3);
    tick();
    for (int n = 0; n < 600; n++) begin
      wq2_rptr = gray_of(n - 3);
      #1;
      check_val("wr_gnt0", gnt0, 1);
      check_val("wr_waddr", waddr, n % 512);
      check_val("wr_wptr", wptr, gray_of(n));
      check_val("wr_wfull", wfull, 0);
      check_val("wr_hfull", hfull, 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter D_Size, default 8: data width in bits.
REQ-002 SHALL have parameter A_Size, default 8: address width; usable depth is 2**A_Size (256).
REQ-003 SHALL have parameter MAX_BURST, default 4: number of accepted beats before ownership may rotate.
REQ-004 SHALL have ports:
- w_clk  in  1  single clock.
- w_rst  in  1  asynchronous active-high reset.
- req0, req1  in  1  write requests from producers 0 and 1.
- wdata0, wdata1  in  D_Size  producer data.
- wq2_rptr  in  A_Size+1  Gray read pointer, already synchronized to w_clk.
- gnt0, gnt1  out  1  beat accepted this cycle.
- w_inc  out  1  memory write strobe.
- wdata  out  D_Size  muxed write data.
- waddr  out  A_Size+1  binary write pointer; memory uses the low A_Size bits.
- wptr  out  A_Size+1  Gray write pointer, sent to the read domain.
- wfull, hfull  out  1  full and half-full flags.

Function
REQ-005 SHALL implement the FSM states IDLE, OWN0 and OWN1.
REQ-006 In IDLE, with any request pending, the FSM SHALL move next cycle to OWN0 or OWN1; if both requesters are pending, it SHALL pick the one that is not last_owner.
REQ-007 No grant SHALL be issued in IDLE; arbitration latency is one cycle.
REQ-008 In OWNx, gnt_x SHALL equal req_x & !wfull, combinationally; the non-owner's grant SHALL be 0.
REQ-009 w_inc SHALL equal gnt0 | gnt1; wdata SHALL be the owner's wdata; at most one grant per cycle.
REQ-010 Each w_inc SHALL increment the binary pointer modulo 2**(A_Size+1) at the w_clk edge; wptr SHALL be registered Gray of the next binary pointer.
REQ-011 A 2-bit beat_cnt SHALL count accepted beats in OWNx, and SHALL clear on any state change.
REQ-012 OWNx transitions:
- req_x low and other requester pending -> OWNy.
- req_x low and no other request -> IDLE.
- beat_cnt reaches MAX_BURST with the other requester pending -> OWNy.
- beat_cnt reaches MAX_BURST with no other request -> stay in OWNx, beat_cnt cleared.
REQ-013 last_owner SHALL update on every exit from OWNx.
REQ-014 While wfull=1, the FSM SHALL hold its state and beat_cnt SHALL NOT advance.
REQ-015 wfull SHALL be registered and asserted when next Gray pointer == {~wq2_rptr[A_Size:A_Size-1], wq2_rptr[A_Size-2:0]}.
REQ-016 hfull SHALL be registered: (next binary pointer - gray2bin(wq2_rptr)) mod 2**(A_Size+1) >= 2**(A_Size-1).
REQ-017 Pointer wrap past 2**(A_Size+1)-1 SHALL roll to 0, with flags remaining correct across the wrap.
REQ-018 A request arriving in the same cycle as wfull deasserting SHALL be granted that cycle.

Reset
REQ-019 Asserting w_rst SHALL asynchronously set:
- state to IDLE, last_owner to 1 (so producer 0 wins first), beat_cnt to 0.
- pointers, wptr and waddr to 0.
- wfull and hfull to 0.
- gnt0, gnt1 and w_inc to 0 immediately.
REQ-020 Reset mid-burst SHALL discard ownership; no write SHALL occur on the edge at which w_rst is high.

Structure
REQ-021 Package fifo_pkg SHALL hold D_Size/A_Size defaults, the state enum and the gray2bin and bin2gray functions.
REQ-022 The block SHALL have no sub-module; the FIFO memory instance lives in the parent.

Verification
REQ-023 Single producer: req0 held, 10 beats, wq2_rptr=0 -> gnt0 from cycle 2 onward, waddr 0..9, wptr = Gray sequence, hfull=0.
REQ-024 Contention: req0 and req1 held from reset -> OWN0 takes 4 beats, then OWN1 takes 4 beats, alternating; no cycle with both grants.
REQ-025 Fill: req0 held, wq2_rptr=0 -> hfull rises after beat 128, wfull rises after beat 256, gnt0=0 thereafter, waddr=256.
REQ-026 Drain during full: with wfull=1, set wq2_rptr=Gray(1) -> wfull drops next cycle, one beat accepted, wfull reasserts.
REQ-027 Wrap: 600 writes with wq2_rptr tracking wptr-3 -> pointer rolls 511->0, flags never assert.
REQ-028 Reset mid-burst: w_rst at beat 2 of OWN1 -> grants 0 immediately; after release, req0 and req1 both pending -> OWN0 first.
